// File: rtl/nes_pad_pkg.sv
// Shared types and constants for the NES pad responder.
// Button bit positions follow the order the pad shifts onto the wire.
package nes_pad_pkg;
  localparam int NUM_BUTTONS = 8;
  localparam int BTN_A      = 7;
  localparam int BTN_B      = 6;
  localparam int BTN_SELECT = 5;
  localparam int BTN_START  = 4;
  localparam int BTN_UP     = 3;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_RIGHT  = 0;

  localparam int BIT_CNT_W = 4;
  localparam logic [BIT_CNT_W-1:0] BIT_LAST = 4'd7;
  localparam logic [BIT_CNT_W-1:0] BIT_FULL = 4'd8;

  typedef enum logic [1:0] {
    PAD_IDLE,
    PAD_LOAD,
    PAD_SHIFT,
    PAD_DONE
  } pad_state_t;
endpackage

// File: rtl/nes_pad_responder_if.sv
// Pad wire bundle between a controller poller and the pad.
// master = poller side, slave = pad side.
interface nes_pad_responder_if;
  logic latch;
  logic pad_clk;
  logic data;

  modport master (
    output latch,
    output pad_clk,
    input  data
  );

  modport slave (
    input  latch,
    input  pad_clk,
    output data
  );
endinterface

// File: rtl/nes_pad_responder_sync_edge.sv
// Multi-flop synchronizer followed by a registered edge detector.
// level/rise/fall are aligned: all come from the same output register.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
      level  <= sync_q[STAGES-1];
      rise   <= sync_q[STAGES-1] & ~level;
      fall   <= ~sync_q[STAGES-1] & level;
    end
  end
endmodule

// File: rtl/nes_pad_responder.sv
// Device end of the NES pad protocol: emulates a standard 8-button
// pad driving an active-low serial data line from latch / pad_clk.
module nes_pad_responder
  import nes_pad_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_BUTTONS-1:0] buttons_in,
  nes_pad_responder_if.slave     pad,
  output logic                   poll_done,
  output logic [COUNT_W-1:0]     poll_count,
  output logic                   busy
);
  logic latch_lvl, latch_fall, latch_rise_unused;
  logic clk_rise, clk_lvl_unused, clk_fall_unused;

  sync_edge #(.STAGES(SYNC_STAGES)) u_latch_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (pad.latch),
    .level    (latch_lvl),
    .rise     (latch_rise_unused),
    .fall     (latch_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_clk_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (pad.pad_clk),
    .level    (clk_lvl_unused),
    .rise     (clk_rise),
    .fall     (clk_fall_unused)
  );

  pad_state_t state_q, state_d;
  logic [NUM_BUTTONS-1:0] shift_q, shift_d;
  logic [BIT_CNT_W-1:0] bit_q, bit_d;
  logic data_q, data_d;
  logic done_d;
  logic [COUNT_W-1:0] count_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PAD_IDLE;
      shift_q    <= 8'hFF;
      bit_q      <= '0;
      data_q     <= 1'b1;
      poll_done  <= 1'b0;
      poll_count <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_q      <= bit_d;
      data_q     <= data_d;
      poll_done  <= done_d;
      poll_count <= count_d;
    end
  end

  // Latch level has priority over everything, including a same-cycle
  // pad_clk edge, so a poll in any state can be restarted.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    data_d  = data_q;
    done_d  = 1'b0;
    count_d = poll_count;
    if (latch_lvl) begin
      state_d = PAD_LOAD;
      shift_d = ~buttons_in;
      data_d  = ~buttons_in[BTN_A];
      bit_d   = '0;
    end else begin
      unique case (state_q)
        PAD_IDLE: data_d = 1'b1;
        PAD_LOAD: begin
          if (latch_fall) state_d = PAD_SHIFT;
        end
        PAD_SHIFT: begin
          if (clk_rise) begin
            shift_d = {shift_q[NUM_BUTTONS-2:0], 1'b0};
            data_d  = shift_d[NUM_BUTTONS-1];
            bit_d   = bit_q + 4'd1;
            if (bit_q == BIT_LAST) begin
              state_d = PAD_DONE;
              done_d  = 1'b1;
              count_d = poll_count + COUNT_W'(1);
              data_d  = 1'b0;
            end
          end
        end
        // Grounded serial input: extra clocks shift in zeros forever.
        PAD_DONE: begin
          data_d = 1'b0;
          bit_d  = BIT_FULL;
        end
        default: state_d = PAD_IDLE;
      endcase
    end
  end

  assign pad.data = data_q;
  assign busy = (state_q == PAD_LOAD) || (state_q == PAD_SHIFT);
endmodule

// File: tb/tb_nes_pad_responder.sv
// Scoreboard bench for nes_pad_responder: pad_clk rises sample data,
// poll_done pulses are matched against expected poll counts.
module tb_nes_pad_responder;
  import nes_pad_pkg::*;

  localparam int SYNC = 2;
  localparam int CW   = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    buttons_in = 8'h00;
  logic          poll_done;
  logic [CW-1:0] poll_count;
  logic          busy;

  nes_pad_responder_if pad_if ();

  nes_pad_responder #(
    .SYNC_STAGES (SYNC),
    .COUNT_W     (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .buttons_in (buttons_in),
    .pad        (pad_if.slave),
    .poll_done  (poll_done),
    .poll_count (poll_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rise_cyc = 0;
  int exp_count = 0;
  bit mon_en   = 1'b0;
  bit bit_q[$];
  int done_q[$];

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Poller-side sampling: data is read just as pad_clk rises.
  always @(posedge pad_if.pad_clk) begin
    rise_cyc = cyc;
    if (mon_en) begin
      if (bit_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_sample: got %0b expected none",
                 pad_if.data);
      end else begin
        check("data_bit", {31'd0, pad_if.data}, {31'd0, bit_q.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (poll_done === 1'b1) begin
      if (done_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_poll_done: got 1 expected 0");
      end else begin
        check("poll_count_at_done", 32'(poll_count), done_q.pop_front());
        check("done_latency", cyc - rise_cyc, SYNC + 2);
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input bit exp);
    bit_q.push_back(exp);
    pad_if.pad_clk = 1'b1;
    wait_clk(8);
    pad_if.pad_clk = 1'b0;
    wait_clk(8);
  endtask

  // pat is the hand-computed wire pattern, first bit in [7].
  task automatic pulses(input logic [7:0] pat, input int from,
                        input int to, input int done_at);
    bit e;
    for (int i = from; i < to; i++) begin
      e = (i < 8) ? pat[7-i] : 1'b0;
      if (i + 1 == done_at) begin
        exp_count++;
        done_q.push_back(exp_count);
      end
      pulse(e);
    end
  endtask

  task automatic do_latch();
    pad_if.latch = 1'b1;
    wait_clk(12);
    pad_if.latch = 1'b0;
    wait_clk(8);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    exp_count = 0;
    wait_clk(2);
  endtask

  task automatic end_check(input string name);
    wait_clk(10);
    check({name, "_pending_done"}, done_q.size(), 0);
    check({name, "_pending_bits"}, bit_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pad_if.latch   = 1'b0;
    pad_if.pad_clk = 1'b0;
    rst_n = 1'b0;

    // 1: reset holds outputs while inputs toggle; idle ignores pad_clk
    for (int i = 0; i < 6; i++) begin
      pad_if.latch   = ~pad_if.latch;
      pad_if.pad_clk = ~pad_if.pad_clk;
      wait_clk(3);
    end
    check("rst_data", {31'd0, pad_if.data}, 1);
    check("rst_poll_done", {31'd0, poll_done}, 0);
    check("rst_poll_count", 32'(poll_count), 0);
    check("rst_busy", {31'd0, busy}, 0);
    pad_if.latch   = 1'b0;
    pad_if.pad_clk = 1'b0;
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(5);
    mon_en = 1'b1;
    pulses(8'hFF, 0, 5, 0);
    check("idle_busy", {31'd0, busy}, 0);
    end_check("t1");

    // 2: A+Right
    do_reset();
    buttons_in = 8'h81;
    do_latch();
    check("t2_busy", {31'd0, busy}, 1);
    pulses(8'b0111_1110, 0, 8, 8);
    end_check("t2");
    check("t2_data_after", {31'd0, pad_if.data}, 0);
    check("t2_count", 32'(poll_count), 1);
    check("t2_busy_after", {31'd0, busy}, 0);

    // 3: extra clocks after the 8th keep data low
    do_reset();
    buttons_in = 8'h81;
    do_latch();
    pulses(8'b0111_1110, 0, 12, 8);
    end_check("t3");
    check("t3_data_after", {31'd0, pad_if.data}, 0);
    check("t3_count", 32'(poll_count), 1);

    // 4: buttons change mid-poll is ignored
    do_reset();
    buttons_in = 8'h00;
    do_latch();
    pulses(8'hFF, 0, 2, 8);
    buttons_in = 8'hFF;
    pulses(8'hFF, 2, 8, 8);
    end_check("t4");
    check("t4_count", 32'(poll_count), 1);

    // 5: relatch after 3 bits aborts and reloads
    do_reset();
    buttons_in = 8'h81;
    do_latch();
    pulses(8'b0111_1110, 0, 3, 8);
    buttons_in = 8'h40;
    do_latch();
    check("t5_a_bit_reload", {31'd0, pad_if.data}, 1);
    check("t5_count_abort", 32'(poll_count), 0);
    pulses(8'b1011_1111, 0, 8, 8);
    end_check("t5");
    check("t5_count", 32'(poll_count), 1);

    // 6: async reset mid-poll after bit 4 (Up pressed -> data low)
    buttons_in = 8'h89;
    do_latch();
    pulses(8'b0111_0110, 0, 4, 8);
    check("t6_data_pre", {31'd0, pad_if.data}, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_data", {31'd0, pad_if.data}, 1);
    check("t6_async_count", 32'(poll_count), 0);
    check("t6_async_busy", {31'd0, busy}, 0);
    wait_clk(3);
    rst_n = 1'b1;
    exp_count = 0;
    wait_clk(3);
    pulses(8'hFF, 0, 4, 0);
    end_check("t6");
    check("t6_busy_after", {31'd0, busy}, 0);
    check("t6_count_after", 32'(poll_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
